// File: rtl/cla_serial_adder_ctrl.sv
// rtl/cla_serial_adder_ctrl.sv - digit-serial wide adder over a 3-bit carry-lookahead slice
module cla_serial_adder_ctrl #(
   parameter int WIDTH = 12,
   parameter int SLICE = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start_valid,
   output logic             start_ready,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic             cin,
   output logic             busy,
   output logic             done_valid,
   input  logic             done_ready,
   output logic [WIDTH:0]   sum
);

   localparam int N  = WIDTH / SLICE;
   localparam int KW = (N > 1) ? $clog2(N) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state_q;
   logic [KW-1:0]    k_q;
   logic             carry_q;
   logic [WIDTH-1:0] a_q;
   logic [WIDTH-1:0] b_q;
   logic [WIDTH:0]   sum_q;
   logic             start_ready_q;
   logic             busy_q;
   logic             done_valid_q;

   int               base;
   logic [SLICE-1:0] slice_a;
   logic [SLICE-1:0] slice_b;
   logic [SLICE:0]   slice_d;

   // Returns {carry_out, sum[2:0]} using generate/propagate lookahead.
   function automatic logic [3:0] cla3(input logic [2:0] x, input logic [2:0] y, input logic ci);
      logic [2:0] g;
      logic [2:0] p;
      logic       c1;
      logic       c2;
      logic       c3;
      g  = x & y;
      p  = x ^ y;
      c1 = g[0] | (p[0] & ci);
      c2 = g[1] | (p[1] & g[0]) | (p[1] & p[0] & ci);
      c3 = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0]) | (p[2] & p[1] & p[0] & ci);
      return {c3, p ^ {c2, c1, ci}};
   endfunction

   always_comb begin
      base    = int'(k_q) * SLICE;
      slice_a = a_q[base +: SLICE];
      slice_b = b_q[base +: SLICE];
      slice_d = cla3(slice_a, slice_b, carry_q);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= IDLE;
         k_q           <= '0;
         carry_q       <= 1'b0;
         a_q           <= '0;
         b_q           <= '0;
         sum_q         <= '0;
         start_ready_q <= 1'b1;
         busy_q        <= 1'b0;
         done_valid_q  <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               // sum_q deliberately keeps the previous result until overwritten
               if (start_valid) begin
                  a_q           <= a;
                  b_q           <= b;
                  carry_q       <= cin;
                  k_q           <= '0;
                  state_q       <= RUN;
                  start_ready_q <= 1'b0;
                  busy_q        <= 1'b1;
               end
            end
            RUN: begin
               sum_q[base +: SLICE] <= slice_d[SLICE-1:0];
               carry_q              <= slice_d[SLICE];
               if (k_q == KW'(N - 1)) begin
                  sum_q[WIDTH] <= slice_d[SLICE];
                  state_q      <= DONE;
                  busy_q       <= 1'b0;
                  done_valid_q <= 1'b1;
               end else begin
                  k_q <= k_q + KW'(1);
               end
            end
            DONE: begin
               if (done_ready) begin
                  state_q       <= IDLE;
                  done_valid_q  <= 1'b0;
                  start_ready_q <= 1'b1;
               end
            end
            default: begin
               state_q       <= IDLE;
               start_ready_q <= 1'b1;
               busy_q        <= 1'b0;
               done_valid_q  <= 1'b0;
            end
         endcase
      end
   end

   assign start_ready = start_ready_q;
   assign busy        = busy_q;
   assign done_valid  = done_valid_q;
   assign sum         = sum_q;

endmodule

// File: tb/tb_cla_serial_adder_ctrl.sv
// tb/tb_cla_serial_adder_ctrl.sv - scoreboard bench for the digit-serial CLA adder
module tb_cla_serial_adder_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start_valid = 1'b0;
   logic        start_ready;
   logic [11:0] a = '0;
   logic [11:0] b = '0;
   logic        cin = 1'b0;
   logic        busy;
   logic        done_valid;
   logic        done_ready = 1'b0;
   logic [12:0] sum;

   int          errors = 0;
   int          checks = 0;
   logic [12:0] exp_q[$];
   bit          rand_en = 1'b0;

   cla_serial_adder_ctrl #(.WIDTH(12), .SLICE(3)) dut (
      .clk(clk), .rst(rst), .start_valid(start_valid), .start_ready(start_ready),
      .a(a), .b(b), .cin(cin), .busy(busy), .done_valid(done_valid),
      .done_ready(done_ready), .sum(sum)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: actual=%h required=%h", name, act, req);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Presents operands until accepted; the expected sum goes onto the scoreboard.
   task automatic issue(input logic [11:0] ta, input logic [11:0] tb_v, input logic tc);
      int n = 0;
      while (!start_ready && n < 200) begin
         step();
         n++;
      end
      if (!start_ready) begin
         checks++;
         errors++;
         $display("FAIL start_timeout: actual=start_ready low required=high");
      end
      a = ta;
      b = tb_v;
      cin = tc;
      start_valid = 1'b1;
      exp_q.push_back({1'b0, ta} + {1'b0, tb_v} + {12'd0, tc});
      step();
      start_valid = 1'b0;
      a = $urandom_range(0, 4095);
      b = $urandom_range(0, 4095);
      cin = $urandom_range(0, 1);
   endtask

   task automatic wait_idle();
      int n = 0;
      while ((exp_q.size() != 0 || !start_ready) && n < 500) begin
         step();
         n++;
      end
      if (n >= 500) begin
         checks++;
         errors++;
         $display("FAIL idle_timeout: actual=pending %0d required=0", exp_q.size());
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         if (!rst && done_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL unexpected_done: actual=sum %h required=no result", sum);
            end else begin
               if (sum !== exp_q[0]) begin
                  errors++;
                  $display("FAIL sum: actual=%h required=%h", sum, exp_q[0]);
               end
               if (done_ready) void'(exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      forever begin
         @(posedge clk);
         if (rand_en) begin
            #1;
            done_ready = $urandom_range(0, 1);
         end
      end
   end

   initial begin
      int cnt;
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
      check("rst_start_ready", start_ready, 1);
      check("rst_busy", busy, 0);
      check("rst_done_valid", done_valid, 0);
      check("rst_sum", sum, 0);

      done_ready = 1'b1;
      issue(12'hFFF, 12'h001, 1'b0);
      cnt = 0;
      while (busy && cnt < 20) begin
         step();
         cnt++;
      end
      check("busy_cycles", cnt, 4);
      check("done_after_run", done_valid, 1);
      wait_idle();

      issue(12'h555, 12'hAAA, 1'b1);
      issue(12'h123, 12'h456, 1'b0);
      wait_idle();

      done_ready = 1'b0;
      issue(12'h0FF, 12'h001, 1'b0);
      cnt = 0;
      while (!done_valid && cnt < 20) begin
         step();
         cnt++;
      end
      for (int i = 0; i < 5; i++) begin
         step();
         check("bp_done_valid", done_valid, 1);
         check("bp_start_ready", start_ready, 0);
      end
      done_ready = 1'b1;
      step();
      check("bp_release_ready", start_ready, 1);
      check("bp_release_done", done_valid, 0);

      issue(12'h100, 12'h200, 1'b0);
      step();
      a = 12'h001;
      b = 12'h000;
      cin = 1'b0;
      start_valid = 1'b1;
      step();
      start_valid = 1'b0;
      wait_idle();

      issue(12'h7FF, 12'h001, 1'b1);
      step();
      rst = 1'b1;
      exp_q.delete();
      step();
      rst = 1'b0;
      check("midrst_start_ready", start_ready, 1);
      check("midrst_busy", busy, 0);
      check("midrst_sum", sum, 0);
      for (int i = 0; i < 6; i++) step();
      issue(12'h007, 12'h007, 1'b0);
      wait_idle();

      rand_en = 1'b1;
      for (int i = 0; i < 1000; i++) begin
         issue(12'($urandom_range(0, 4095)), 12'($urandom_range(0, 4095)), 1'($urandom_range(0, 1)));
      end
      wait_idle();
      rand_en = 1'b0;
      check("scoreboard_empty", exp_q.size(), 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
